// File: rtl/color_mix_fade.sv
// Pipelined RGB-to-luma colour/monochrome mixer with whole-frame crossfade between modes.
// Optional build macro COLOR_MIX_BLANK_EN blanks pixel data whenever the delayed HBlank or VBlank is high.
`timescale 1ns/1ps
module color_mix_fade #(
  parameter int DW        = 8,
  parameter int FADE_LOG2 = 2
) (
  input  logic          clk_vid,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic [2:0]    mix,
  input  logic [7:0]    tint_r,
  input  logic [7:0]    tint_g,
  input  logic [7:0]    tint_b,
  input  logic [DW-1:0] R_in,
  input  logic [DW-1:0] G_in,
  input  logic [DW-1:0] B_in,
  input  logic          HSync_in,
  input  logic          VSync_in,
  input  logic          HBlank_in,
  input  logic          VBlank_in,
  output logic [DW-1:0] R_out,
  output logic [DW-1:0] G_out,
  output logic [DW-1:0] B_out,
  output logic          HSync_out,
  output logic          VSync_out,
  output logic          HBlank_out,
  output logic          VBlank_out,
  output logic          fade_busy
);
  localparam int AW = FADE_LOG2 + 1;
  localparam int BW = DW + FADE_LOG2 + 1;
  localparam logic [AW-1:0] ALPHA_MAX = AW'(2 ** FADE_LOG2);

  typedef enum logic {IDLE, FADE} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_alpha, w_alpha_nxt, w_alpha_inc, w_blend_alpha;
  logic [2:0]    r_active, r_target, w_active_nxt, w_target_nxt, w_mode_a;
  logic          r_init, w_rise, w_fading, w_use_target;

  // Timing bits are packed as {HSync, VSync, HBlank, VBlank} through the pipeline.
  logic [DW-1:0] r_s1_r, r_s1_g, r_s1_b, r_s2_r, r_s2_g, r_s2_b, r_s2_y;
  logic [3:0]    r_s1_tim, r_s2_tim;
  logic [DW+7:0] w_sum;
  logic [3*DW-1:0] w_pa, w_pt, w_blend, w_pix;

  function automatic logic [3*DW-1:0] mode_pix(input logic [2:0] m,
      input logic [DW-1:0] r, g, b, y, input logic [7:0] tr, tg, tb);
    logic [DW-1:0] z;
    logic [DW+7:0] pr, pg, pb;
    z  = '0;
    pr = (DW+8)'(y) * (DW+8)'(tr);
    pg = (DW+8)'(y) * (DW+8)'(tg);
    pb = (DW+8)'(y) * (DW+8)'(tb);
    case (m)
      3'd0, 3'd1: mode_pix = {r, g, b};
      3'd2:       mode_pix = {z, y, z};
      3'd3:       mode_pix = {y, y - (y >> 2), z};
      3'd4:       mode_pix = {z, y, y};
      3'd5:       mode_pix = {y, y, y};
      default:    mode_pix = {pr[DW+7:8], pg[DW+7:8], pb[DW+7:8]};
    endcase
  endfunction

  assign w_sum = (DW+8)'(r_s1_r) * (DW+8)'(54) + (DW+8)'(r_s1_g) * (DW+8)'(183)
               + (DW+8)'(r_s1_b) * (DW+8)'(18);

  // S3 sees the previous S2 VBlank on VBlank_out, so this is a rising edge at S2.
  assign w_rise      = r_s2_tim[0] & ~VBlank_out;
  assign w_alpha_inc = r_alpha + AW'(1);
  assign w_mode_a    = r_init ? mix : r_active;
  assign fade_busy   = (r_state == FADE);

  always_comb begin
    w_state_nxt   = r_state;
    w_alpha_nxt   = r_alpha;
    w_active_nxt  = r_active;
    w_target_nxt  = r_target;
    w_blend_alpha = r_alpha;
    w_fading      = 1'b0;
    w_use_target  = 1'b0;
    if (r_init) begin
      w_active_nxt = mix;
    end else begin
      case (r_state)
        IDLE: begin
          if (mix != r_active) begin
            if (FADE_LOG2 == 0) begin
              w_active_nxt = mix;
            end else begin
              w_target_nxt = mix;
              w_alpha_nxt  = '0;
              w_state_nxt  = FADE;
            end
          end
        end
        FADE: begin
          w_fading = 1'b1;
          if (w_rise) begin
            if (w_alpha_inc == ALPHA_MAX) begin
              w_active_nxt = r_target;
              w_alpha_nxt  = '0;
              w_state_nxt  = IDLE;
              w_fading     = 1'b0;
              w_use_target = 1'b1;
            end else begin
              w_alpha_nxt   = w_alpha_inc;
              w_blend_alpha = w_alpha_inc;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_pa = mode_pix(w_mode_a, r_s2_r, r_s2_g, r_s2_b, r_s2_y, tint_r, tint_g, tint_b);
  assign w_pt = mode_pix(r_target, r_s2_r, r_s2_g, r_s2_b, r_s2_y, tint_r, tint_g, tint_b);

  for (genvar c = 0; c < 3; c++) begin : g_blend
    logic [BW-1:0] w_mix_sum;
    assign w_mix_sum = BW'(w_pa[c*DW +: DW]) * BW'(ALPHA_MAX - w_blend_alpha)
                     + BW'(w_pt[c*DW +: DW]) * BW'(w_blend_alpha);
    assign w_blend[c*DW +: DW] = w_mix_sum[FADE_LOG2 +: DW];
  end

  always_comb begin
    w_pix = w_pa;
    if (w_use_target) begin
      w_pix = w_pt;
    end else if (w_fading) begin
      w_pix = w_blend;
    end
`ifdef COLOR_MIX_BLANK_EN
    if (r_s2_tim[1] | r_s2_tim[0]) begin
      w_pix = '0;
    end
`endif
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      r_s1_r <= '0; r_s1_g <= '0; r_s1_b <= '0; r_s1_tim <= '0;
      r_s2_r <= '0; r_s2_g <= '0; r_s2_b <= '0; r_s2_y <= '0; r_s2_tim <= '0;
      R_out <= '0; G_out <= '0; B_out <= '0;
      {HSync_out, VSync_out, HBlank_out, VBlank_out} <= '0;
      r_state  <= IDLE;
      r_alpha  <= '0;
      r_active <= '0;
      r_target <= '0;
      r_init   <= 1'b1;
    end else if (ce_pix) begin
      r_s1_r   <= R_in;
      r_s1_g   <= G_in;
      r_s1_b   <= B_in;
      r_s1_tim <= {HSync_in, VSync_in, HBlank_in, VBlank_in};
      r_s2_r   <= r_s1_r;
      r_s2_g   <= r_s1_g;
      r_s2_b   <= r_s1_b;
      r_s2_y   <= w_sum[DW+7:8];
      r_s2_tim <= r_s1_tim;
      {R_out, G_out, B_out} <= w_pix;
      {HSync_out, VSync_out, HBlank_out, VBlank_out} <= r_s2_tim;
      r_state  <= w_state_nxt;
      r_alpha  <= w_alpha_nxt;
      r_active <= w_active_nxt;
      r_target <= w_target_nxt;
      r_init   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_color_mix_fade.sv
// Directed bench for color_mix_fade (DW=8, FADE_LOG2=2): expected pixels/timing queued at drive time,
// compared when they leave the 3-stage pipeline.
`timescale 1ns/1ps
module tb_color_mix_fade;
  localparam int DW = 8;
  localparam int W  = 29;  // {check_pixel, R, G, B, HS, VS, HB, VB}

  logic          clk_vid = 1'b0;
  logic          reset = 1'b1;
  logic          ce_pix = 1'b1;
  logic [2:0]    mix = 3'd5;
  logic [7:0]    tint_r = 8'd0, tint_g = 8'd0, tint_b = 8'd0;
  logic [DW-1:0] R_in = 8'd255, G_in = 8'd255, B_in = 8'd255;
  logic          HSync_in = 1'b1, VSync_in = 1'b1, HBlank_in = 1'b1, VBlank_in = 1'b1;
  logic [DW-1:0] R_out, G_out, B_out;
  logic          HSync_out, VSync_out, HBlank_out, VBlank_out, fade_busy;

  logic [W-1:0]  exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;

  color_mix_fade #(.DW(DW), .FADE_LOG2(2)) dut (
    .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix), .mix(mix),
    .tint_r(tint_r), .tint_g(tint_g), .tint_b(tint_b),
    .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .HSync_in(HSync_in), .VSync_in(VSync_in), .HBlank_in(HBlank_in), .VBlank_in(VBlank_in),
    .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .HSync_out(HSync_out), .VSync_out(VSync_out), .HBlank_out(HBlank_out), .VBlank_out(VBlank_out),
    .fade_busy(fade_busy)
  );

  always #5 clk_vid = ~clk_vid;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_y(input logic [23:0] px);
    int s;
    s = int'(px[23:16]) * 54 + int'(px[15:8]) * 183 + int'(px[7:0]) * 18;
    return 8'(s / 256);
  endfunction

  function automatic logic [23:0] ref_p(input int m, input logic [23:0] px);
    logic [7:0] y;
    y = ref_y(px);
    case (m)
      0, 1:    return px;
      2:       return {8'd0, y, 8'd0};
      3:       return {y, 8'(y - y / 4), 8'd0};
      4:       return {8'd0, y, y};
      5:       return {y, y, y};
      default: return {8'((int'(y) * int'(tint_r)) / 256), 8'((int'(y) * int'(tint_g)) / 256),
                       8'((int'(y) * int'(tint_b)) / 256)};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One ce_pix pixel, then `idle` cycles with ce_pix low during which outputs must hold.
  task automatic step(input logic [23:0] px, input logic [3:0] tim, input logic [23:0] e,
                      input logic chk, input int idle);
    logic [W-1:0]  ent;
    logic [23:0]   ee;
    ee = e;
`ifdef COLOR_MIX_BLANK_EN
    if (tim[1] | tim[0]) ee = 24'd0;
`endif
    {R_in, G_in, B_in} = px;
    {HSync_in, VSync_in, HBlank_in, VBlank_in} = tim;
    ce_pix = 1'b1;
    exp_q.push_back({chk, ee, tim});
    @(posedge clk_vid); #1;
    ce_pix = 1'b0;
    ent = exp_q.pop_front();
    check("timing", {HSync_out, VSync_out, HBlank_out, VBlank_out}, ent[3:0]);
    if (ent[28]) check("pixel", {R_out, G_out, B_out}, ent[27:4]);
    for (int i = 0; i < idle; i++) begin
      @(posedge clk_vid); #1;
      check("hold_timing", {HSync_out, VSync_out, HBlank_out, VBlank_out}, ent[3:0]);
      if (ent[28]) check("hold_pixel", {R_out, G_out, B_out}, ent[27:4]);
    end
  endtask

  task automatic do_reset(input logic [2:0] m);
    mix = m;
    exp_q.delete();
    reset = 1'b1;
    ce_pix = 1'b1;
    @(posedge clk_vid); #1;
    check("reset_outputs", {R_out, G_out, B_out, HSync_out, VSync_out, HBlank_out, VBlank_out,
                            fade_busy}, 32'd0);
    reset = 1'b0;
    ce_pix = 1'b0;
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  // 6 active pixels then 4 vertical-blank pixels; the first blank pixel carries the VBlank rise.
  task automatic frame(input logic [23:0] px, input logic [23:0] ea, input logic [23:0] eb,
                       input logic ca, input logic cb);
    for (int i = 0; i < 6; i++) step(px, {i == 1, 1'b0, i == 5, 1'b0}, ea, ca, 0);
    for (int i = 0; i < 4; i++) step(px, {1'b0, i == 1, 1'b1, 1'b1}, eb, cb, 0);
  endtask

  logic [23:0] px;
  logic [23:0] amber, tint6, cyan;

  initial begin
    // Init path: gray loaded directly from mix, no fade.
    @(posedge clk_vid); #1;
    do_reset(3'd5);
    for (int i = 0; i < 6; i++) step(24'hFFFFFF, 4'(i), 24'hFEFEFE, 1'b1, 0);
    check("init_no_fade", {31'd0, fade_busy}, 32'd0);

    // Amber, then fade to custom tint.
    amber = {8'd254, 8'd191, 8'd0};
    tint6 = {8'd127, 8'd253, 8'd0};
    do_reset(3'd3);
    for (int i = 0; i < 5; i++) step(24'hFFFFFF, 4'b0000, amber, 1'b1, 0);
    tint_r = 8'd128; tint_g = 8'd255; tint_b = 8'd0;
    mix = 3'd6;
    frame(24'hFFFFFF, amber, 24'd0, 1'b1, 1'b0);
    frame(24'hFFFFFF, 24'd0, 24'd0, 1'b0, 1'b0);
    frame(24'hFFFFFF, 24'd0, 24'd0, 1'b0, 1'b0);
    frame(24'hFFFFFF, 24'd0, tint6, 1'b0, 1'b1);
    frame(24'hFFFFFF, tint6, tint6, 1'b1, 1'b1);
    check("tint_idle", {31'd0, fade_busy}, 32'd0);
    check("tint_model", {8'd0, tint6}, {8'd0, ref_p(6, 24'hFFFFFF)});

    // Colour -> green crossfade over four frames.
    px = 24'hFF0000;
    do_reset(3'd0);
    frame(px, px, px, 1'b1, 1'b1);
    mix = 3'd2;
    frame(px, px, {8'd191, 8'd13, 8'd0}, 1'b1, 1'b1);
    check("fade_busy_f0", {31'd0, fade_busy}, 32'd1);
    frame(px, {8'd191, 8'd13, 8'd0}, {8'd127, 8'd26, 8'd0}, 1'b1, 1'b1);
    frame(px, {8'd127, 8'd26, 8'd0}, {8'd63, 8'd39, 8'd0}, 1'b1, 1'b1);
    check("fade_busy_f2", {31'd0, fade_busy}, 32'd1);
    frame(px, {8'd63, 8'd39, 8'd0}, {8'd0, 8'd53, 8'd0}, 1'b1, 1'b1);
    check("fade_done", {31'd0, fade_busy}, 32'd0);
    frame(px, {8'd0, 8'd53, 8'd0}, {8'd0, 8'd53, 8'd0}, 1'b1, 1'b1);

    // Quarter-rate ce_pix with random pixels and timing, colour then gray.
    do_reset(3'd0);
    for (int i = 0; i < 16; i++) begin
      px = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      step(px, 4'($urandom_range(0, 15)), px, 1'b1, 3);
    end
    do_reset(3'd5);
    for (int i = 0; i < 12; i++) begin
      px = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      step(px, 4'($urandom_range(0, 15)), ref_p(5, px), 1'b1, 3);
    end

    // Mid-fade mix change is ignored; reset during the fade aborts it, re-init goes straight to cyan.
    px = 24'hFF0000;
    cyan = {8'd0, 8'd53, 8'd53};
    do_reset(3'd0);
    frame(px, px, px, 1'b1, 1'b1);
    mix = 3'd2;
    frame(px, px, {8'd191, 8'd13, 8'd0}, 1'b1, 1'b1);
    mix = 3'd4;
    frame(px, {8'd191, 8'd13, 8'd0}, {8'd127, 8'd26, 8'd0}, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(px, 4'b0000, {8'd127, 8'd26, 8'd0}, 1'b1, 0);
    check("busy_before_reset", {31'd0, fade_busy}, 32'd1);
    do_reset(3'd4);
    frame(px, cyan, cyan, 1'b1, 1'b1);
    check("busy_after_reset", {31'd0, fade_busy}, 32'd0);

    // Pixel under HBlank: blanked to zero only when the blank option is built in.
    do_reset(3'd0);
    step({8'd200, 8'd100, 8'd50}, 4'b0010, {8'd200, 8'd100, 8'd50}, 1'b1, 0);
    for (int i = 0; i < 3; i++) step({8'd200, 8'd100, 8'd50}, 4'b0000, {8'd200, 8'd100, 8'd50}, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/color_mix_fade.md
Name: color_mix_fade

Overview:
- Parametrised, pipelined successor to the per-pixel colour/monochrome mixer.
- Sits between the core video output and the scaler/OSD path on clk_vid.
- Converts RGB to luma and outputs colour, green, amber, cyan, gray or a programmable tint.
- Crossfades over whole frames when the mode changes, with sync and blank delayed to match the pixel pipeline.

Parameters:
- DW, 8, colour channel width in bits (minimum 4).
- FADE_LOG2, 2, crossfade length is 2^FADE_LOG2 frames; 0 means instant switch.

Ports:
- clk_vid  in  1  video clock.
- reset  in  1  synchronous, active-high reset, sampled on the clk_vid rising edge.
- ce_pix  in  1  pixel enable; all state advances only when high (reset excepted).
- mix  in  3  mode: 0/1 colour, 2 green, 3 amber, 4 cyan, 5 gray, 6/7 custom tint.
- tint_r, tint_g, tint_b  in  8 each  custom tint gains, unsigned, scale 1/256.
- R_in, G_in, B_in  in  DW each  input pixel.
- HSync_in, VSync_in, HBlank_in, VBlank_in  in  1 each  input timing.
- R_out, G_out, B_out  out  DW each  mixed pixel.
- HSync_out, VSync_out, HBlank_out, VBlank_out  out  1 each  delayed timing.
- fade_busy  out  1  high while a crossfade is in progress.

Behaviour:
- Reset: every output is 0; all pipeline registers are 0; state IDLE; alpha 0; active mode 0; init flag set.
- Pipeline: 3 ce_pix stages.
  - S1 registers the inputs.
  - S2 computes luma Y.
  - S3 does mode select, fade blend and the output register.
  - Input at ce_pix edge n appears on the outputs at ce_pix edge n+3.
  - Sync/blank pass through a 3-stage delay, so they stay aligned with pixel data.
  - Outputs hold while ce_pix is low.
- Luma:
  - sum = R*54 + G*183 + B*18, width DW+8 bits, no overflow.
  - Y = sum[DW+7:8].
- Mode pixel P(m):
  - colour: (R,G,B).
  - green: (0,Y,0).
  - amber: (Y, Y-(Y>>2), 0).
  - cyan: (0,Y,Y).
  - gray: (Y,Y,Y).
  - tint: each channel = (Y*tint_x)>>8, truncated.
- Init: on the first ce_pix after reset, active mode is loaded directly from mix with no fade, and the init flag clears.
- State IDLE:
  - Output = P(active).
  - If mix != active, latch target = mix and enter FADE with alpha = 0.
  - If FADE_LOG2 = 0, set active = mix instead and stay in IDLE.
- State FADE:
  - fade_busy = 1.
  - Per channel: out = (P(active)*(2^L - alpha) + P(target)*alpha) >> L, with L = FADE_LOG2 and intermediate width DW+L+1.
  - alpha increments by 1 on each VBlank rising edge, detected on S2-stage VBlank at ce_pix.
  - When alpha reaches 2^L on that edge: active = target, alpha = 0, return to IDLE. The output equals P(target) from that same pixel onward.
  - A change of mix during FADE is ignored. After returning to IDLE the mismatch is detected and a new fade starts on the next ce_pix.
- Tint gains are sampled live and are not frame-latched.
- Reset mid-fade aborts immediately to the reset state. The next ce_pix re-initialises from mix with no fade.

Optional Feature:
- Macro: COLOR_MIX_BLANK_EN.
- Defined: R_out, G_out and B_out are forced to 0 on any S3 pixel whose delayed HBlank or VBlank is 1; timing outputs are unaffected.
- Undefined: pixel data passes through during blanking exactly as computed.

Test Plan:
- Reset, mix=5, input R=G=B=255 with ce_pix every cycle -> outputs 0 during reset; after 3 ce_pix, R=G=B=254 and fade_busy stays 0 (init path).
- mix=3, input R=G=B=255 -> R=254, G=191, B=0. Then mix=6 (after the fade completes) with tint_r=128, tint_g=255, tint_b=0 -> (127,253,0).
- FADE_LOG2=2, active=0, input (255,0,0), switch mix to 2 -> per frame (191,13,0), (127,26,0), (63,39,0), then (0,53,0). fade_busy drops at the 4th VBlank rise.
- Toggle ce_pix at 1/4 rate -> data and HSync/VSync/HBlank/VBlank edges emerge exactly 3 ce_pix later, with identical alignment.
- Mid-fade change mix 2->4, then assert reset for one cycle during the second fade frame -> fade_busy = 0 and outputs 0 during reset; afterwards output is cyan directly, with no fade.
- With COLOR_MIX_BLANK_EN defined, input (200,100,50) and HBlank=1 -> RGB out = 0; HBlank_out = 1 three ce_pix later.
